sata_link_rx_ctrl: RTL

Receive-side Link-layer controller for SerialATA. It sits between the primitive decoder and the receive datapath (descrambler → CRC checker → RX FIFO). It runs the receive handshake (X_RDY/R_RDY/SOF/R_IP/HOLD/HOLDA/EOF/WTRM/R_OK/R_ERR) and strips primitives from the data stream. It drives the datapath's rx_dat/rx_val/rx_eop and turns the datapath's CRC and overflow status into the frame-end R_OK or R_ERR reply.

---
 rtl/sata_link_pkg.sv | 52 +++++
 rtl/sata_link_rx_skid.sv | 48 ++++
 rtl/sata_link_rx_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/sata_link_pkg.sv
// Shared types for the SATA link-layer receive controller: primitive codes,
// receive FSM states and the state-to-primitive mapping.
package sata_link_pkg;

    // Primitive codes exchanged with the primitive decoder / encoder.
    // PRIM_NONE marks a data dword.
    typedef enum logic [3:0] {
        PRIM_NONE  = 4'd0,
        PRIM_SYNC  = 4'd1,
        PRIM_X_RDY = 4'd2,
        PRIM_R_RDY = 4'd3,
        PRIM_SOF   = 4'd4,
        PRIM_EOF   = 4'd5,
        PRIM_HOLD  = 4'd6,
        PRIM_HOLDA = 4'd7,
        PRIM_R_IP  = 4'd8,
        PRIM_WTRM  = 4'd9,
        PRIM_R_OK  = 4'd10,
        PRIM_R_ERR = 4'd11,
        PRIM_DMAT  = 4'd12
    } sata_prim_t;

    // Receive handshake states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RDY       = 3'd1,
        ST_DATA      = 3'd2,
        ST_LHOLD     = 3'd3,
        ST_PHOLD     = 3'd4,
        ST_WAIT_STAT = 3'd5,
        ST_GOOD      = 3'd6,
        ST_BAD       = 3'd7
    } sata_link_rx_state_t;

    localparam int FRAME_CNT_W = 16;

    // Primitive transmitted continuously while in a given state.
    function automatic sata_prim_t state_prim(input sata_link_rx_state_t s);
        case (s)
            ST_IDLE:      state_prim = PRIM_SYNC;
            ST_RDY:       state_prim = PRIM_R_RDY;
            ST_DATA:      state_prim = PRIM_R_IP;
            ST_LHOLD:     state_prim = PRIM_HOLD;
            ST_PHOLD:     state_prim = PRIM_HOLDA;
            ST_WAIT_STAT: state_prim = PRIM_R_IP;
            ST_GOOD:      state_prim = PRIM_R_OK;
            ST_BAD:       state_prim = PRIM_R_ERR;
            default:      state_prim = PRIM_SYNC;
        endcase
    endfunction

endpackage

// File: rtl/sata_link_rx_skid.sv
// One-dword hold register between the link receive FSM and the datapath.
// A dword is only released once the next dword arrives (rx_eop=0) or the
// frame ends / aborts (rx_eop=1), so the CRC dword always carries rx_eop.
module sata_link_rx_skid (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        store,    // accept din; release any held dword
    input  logic [31:0] din,
    input  logic        eop,      // frame end: release held dword with eop
    input  logic        flush,    // abort: release held dword (if any) with eop
    output logic [31:0] dout,
    output logic        val,
    output logic        last,
    output logic        full
);

    logic [31:0] hold;

    // Hold register and registered datapath outputs; close beats store.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
            full <= 1'b0;
            dout <= '0;
            val  <= 1'b0;
            last <= 1'b0;
        end else begin
            val  <= 1'b0;
            last <= 1'b0;
            if (eop || flush) begin
                if (full) begin
                    dout <= hold;
                    val  <= 1'b1;
                    last <= 1'b1;
                end
                full <= 1'b0;
            end else if (store) begin
                if (full) begin
                    dout <= hold;
                    val  <= 1'b1;
                end
                hold <= din;
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sata_link_rx_ctrl.sv
// SATA link-layer receive controller: runs the receive primitive handshake,
// strips primitives, forwards data through a one-dword skid register and
// answers each frame with R_OK / R_ERR from the datapath status.
// Optional build macro SATA_LINK_RX_FRAME_CNT_EN adds saturating frame
// counters cnt_good / cnt_bad / cnt_abort.
//
// Datapath handshake: rx_val qualifies rx_dat/rx_eop for exactly one cycle
// and is always consumed; the datapath has no ready (its o_rdy is tied high),
// so local flow control is done only through HOLD on fifo_almostfull.
module sata_link_rx_ctrl
    import sata_link_pkg::*;
#(
    parameter int STAT_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        link_up,
    input  logic [31:0] phy_dat,
    input  logic        phy_val,
    input  sata_prim_t  phy_prim,
    output logic [31:0] rx_dat,
    output logic        rx_val,
    output logic        rx_eop,
    input  logic        fifo_almostfull,
    input  logic        stat_good_crc,
    input  logic        stat_bad_crc,
    input  logic        stat_fifo_ovfl,
    output sata_prim_t  tx_prim,
    output logic        frame_active
`ifdef SATA_LINK_RX_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] cnt_good,
    output logic [FRAME_CNT_W-1:0] cnt_bad,
    output logic [FRAME_CNT_W-1:0] cnt_abort
`endif
);

    localparam int TW = $clog2(STAT_TIMEOUT) + 1;

    sata_link_rx_state_t state, state_next;
    logic [TW-1:0]       to_cnt;
    logic                ovfl_flag;
    logic                skid_full;
    logic                store, emit_eop, flush, abort;
    logic                in_frame;

    // Decoded receive events; primitives only count when phy_val is set.
    logic is_data, is_sync, is_xrdy, is_sof, is_eof, is_hold;
    assign is_data = phy_val && (phy_prim == PRIM_NONE);
    assign is_sync = phy_val && (phy_prim == PRIM_SYNC);
    assign is_xrdy = phy_val && (phy_prim == PRIM_X_RDY);
    assign is_sof  = phy_val && (phy_prim == PRIM_SOF);
    assign is_eof  = phy_val && (phy_prim == PRIM_EOF);
    assign is_hold = phy_val && (phy_prim == PRIM_HOLD);

    assign in_frame = (state == ST_DATA) || (state == ST_LHOLD) || (state == ST_PHOLD);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next state and skid controls; link loss beats everything, then SYNC.
    always_comb begin
        state_next = state;
        store      = 1'b0;
        emit_eop   = 1'b0;
        flush      = 1'b0;
        abort      = 1'b0;
        if (!link_up) begin
            state_next = ST_IDLE;
            if (state != ST_IDLE) begin
                abort = 1'b1;
                flush = 1'b1;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_xrdy) state_next = ST_RDY;
                end
                ST_RDY: begin
                    if (is_sof)       state_next = ST_DATA;
                    else if (is_sync) state_next = ST_IDLE;
                end
                ST_DATA, ST_LHOLD, ST_PHOLD: begin
                    if (is_sync) begin
                        state_next = ST_IDLE;
                        abort      = 1'b1;
                        flush      = 1'b1;
                    end else if (is_eof) begin
                        // An EOF without a held CRC dword is a malformed frame.
                        if (skid_full) begin
                            emit_eop   = 1'b1;
                            state_next = ST_WAIT_STAT;
                        end else begin
                            state_next = ST_BAD;
                        end
                    end else begin
                        store = is_data;
                        // Local HOLD always wins over answering the peer's HOLD.
                        if (fifo_almostfull) begin
                            state_next = ST_LHOLD;
                        end else if (is_hold) begin
                            state_next = ST_PHOLD;
                        end else if (state == ST_LHOLD || phy_val) begin
                            state_next = ST_DATA;
                        end
                    end
                end
                ST_WAIT_STAT: begin
                    if (stat_bad_crc || ovfl_flag || stat_fifo_ovfl) state_next = ST_BAD;
                    else if (stat_good_crc)                           state_next = ST_GOOD;
                    else if (to_cnt == TW'(STAT_TIMEOUT - 1))         state_next = ST_BAD;
                end
                ST_GOOD, ST_BAD: begin
                    if (is_sync) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Registered handshake outputs follow the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_prim      <= PRIM_SYNC;
            frame_active <= 1'b0;
        end else begin
            tx_prim      <= state_prim(state_next);
            frame_active <= (state_next != ST_IDLE) && (state_next != ST_RDY);
        end
    end

    // Status timeout: cleared on entry to WAIT_STAT, saturating inside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state_next == ST_WAIT_STAT && state != ST_WAIT_STAT) begin
            to_cnt <= '0;
        end else if (state == ST_WAIT_STAT && to_cnt != {TW{1'b1}}) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Sticky overflow seen anywhere between SOF and the end of WAIT_STAT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovfl_flag <= 1'b0;
        end else if (state == ST_IDLE) begin
            ovfl_flag <= 1'b0;
        end else if (stat_fifo_ovfl && (in_frame || state == ST_WAIT_STAT)) begin
            ovfl_flag <= 1'b1;
        end
    end

    sata_link_rx_skid u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .store   (store),
        .din     (phy_dat),
        .eop     (emit_eop),
        .flush   (flush),
        .dout    (rx_dat),
        .val     (rx_val),
        .last    (rx_eop),
        .full    (skid_full)
    );

`ifdef SATA_LINK_RX_FRAME_CNT_EN
    // Saturating frame outcome counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_good  <= '0;
            cnt_bad   <= '0;
            cnt_abort <= '0;
        end else begin
            if (state_next == ST_GOOD && state != ST_GOOD && cnt_good != '1)
                cnt_good <= cnt_good + 1'b1;
            if (state_next == ST_BAD && state != ST_BAD && cnt_bad != '1)
                cnt_bad <= cnt_bad + 1'b1;
            if (abort && cnt_abort != '1)
                cnt_abort <= cnt_abort + 1'b1;
        end
    end
`endif

endmodule
